// File: rtl/life_ctrl_pkg.sv
// Shared constants for the life tile array sequencer: FSM encoding, halt codes
// and default bus widths.
package life_ctrl_pkg;

    localparam int unsigned CELLS_DEF = 16;
    localparam int unsigned GEN_W_DEF = 16;
    localparam int unsigned DIV_W_DEF = 24;

    typedef logic [2:0] state_t;
    typedef logic [1:0] halt_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_STEP  = 3'd3;
    localparam state_t ST_CHECK = 3'd4;

    localparam halt_t HALT_NONE   = 2'b00;
    localparam halt_t HALT_STABLE = 2'b01;
    localparam halt_t HALT_EMPTY  = 2'b10;
    localparam halt_t HALT_MAXGEN = 2'b11;

endpackage

// File: rtl/life_step_timer.sv
// Inter-generation delay: down-counter reloaded with the period on WAIT entry.
module life_step_timer
    import life_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    output logic             expired
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] one;

    assign one = {{(DIV_W-1){1'b0}}, 1'b1};

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = period;
        end else if (count_q != '0) begin
            count_d = count_q - one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire while the count reads 1 so WAIT occupies exactly `period` cycles.
    assign expired = (count_q <= one);

endmodule

// File: rtl/life_ctrl.sv
// Sequencer for the life tile array: loads a pattern, paces single-generation
// step pulses, counts generations and reports why a run halted.
module life_ctrl
    import life_ctrl_pkg::*;
#(
    parameter int unsigned CELLS = CELLS_DEF,
    parameter int unsigned GEN_W = GEN_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_load,
    input  logic [CELLS-1:0] load_val,
    input  logic             cmd_run,
    input  logic             cmd_single,
    input  logic             cmd_stop,
    input  logic [DIV_W-1:0] period,
    input  logic [GEN_W-1:0] max_gen,
    input  logic [CELLS-1:0] alive_in,
    output logic [CELLS-1:0] val_out,
    output logic             write_enb_out,
    output logic             step_out,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic [1:0]       halt_reason,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CELLS-1:0] val_q, val_d;
    logic [CELLS-1:0] prev_q, prev_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    halt_t            halt_q, halt_d;
    logic             done_q, done_d;
    logic             single_q, single_d;
    logic             stop_q, stop_d;

    logic             timer_load;
    logic             timer_expired;
    logic [GEN_W-1:0] gen_inc;
    halt_t            halt_chk;

    life_step_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .period (period),
        .expired(timer_expired)
    );

    always_comb begin
        gen_inc = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);

        // Priority: empty > stable > generation limit.
        halt_chk = HALT_NONE;
        if (alive_in == '0) begin
            halt_chk = HALT_EMPTY;
        end else if (alive_in == prev_q) begin
            halt_chk = HALT_STABLE;
        end else if (max_gen != '0 && gen_inc == max_gen) begin
            halt_chk = HALT_MAXGEN;
        end
    end

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        prev_d     = prev_q;
        gen_d      = gen_q;
        halt_d     = halt_q;
        done_d     = 1'b0;
        single_d   = single_q;
        stop_d     = stop_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                // cmd_stop wins in IDLE and does nothing.
                if (!cmd_stop) begin
                    if (cmd_load) begin
                        state_d = ST_LOAD;
                        val_d   = load_val;
                        halt_d  = HALT_NONE;
                    end else if (cmd_single || cmd_run) begin
                        single_d = cmd_single;
                        halt_d   = HALT_NONE;
                        if (period == '0) begin
                            state_d = ST_STEP;
                        end else begin
                            state_d    = ST_WAIT;
                            timer_load = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: begin
                prev_d  = val_q;
                gen_d   = '0;
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (cmd_stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else if (timer_expired) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (cmd_stop) begin
                    stop_d = 1'b1;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                gen_d  = gen_inc;
                halt_d = halt_chk;
                prev_d = alive_in;
                if (halt_chk != HALT_NONE || single_q || stop_q || cmd_stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else if (period == '0) begin
                    state_d = ST_STEP;
                end else begin
                    state_d    = ST_WAIT;
                    timer_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            val_q    <= '0;
            prev_q   <= '0;
            gen_q    <= '0;
            halt_q   <= HALT_NONE;
            done_q   <= 1'b0;
            single_q <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            prev_q   <= prev_d;
            gen_q    <= gen_d;
            halt_q   <= halt_d;
            done_q   <= done_d;
            single_q <= single_d;
            stop_q   <= stop_d;
        end
    end

    // Array-facing strobes decode the registered state only.
    assign val_out       = val_q;
    assign write_enb_out = (state_q == ST_LOAD);
    assign step_out      = (state_q == ST_STEP);
    assign busy          = (state_q != ST_IDLE);
    assign gen_count     = gen_q;
    assign halt_reason   = halt_q;
    assign done          = done_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Randomized scoreboard bench for life_ctrl with a 4x4 Game of Life array model
// (dead border) and a generation-level reference model.
module tb_life_ctrl;

    localparam int unsigned CELLS = 16;
    localparam int unsigned GEN_W = 16;
    localparam int unsigned DIV_W = 24;

    logic             clk;
    logic             reset;
    logic             cmd_load;
    logic [CELLS-1:0] load_val;
    logic             cmd_run;
    logic             cmd_single;
    logic             cmd_stop;
    logic [DIV_W-1:0] period;
    logic [GEN_W-1:0] max_gen;
    logic [CELLS-1:0] alive_in;
    logic [CELLS-1:0] val_out;
    logic             write_enb_out;
    logic             step_out;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic [1:0]       halt_reason;
    logic             done;

    life_ctrl #(
        .CELLS(CELLS),
        .GEN_W(GEN_W),
        .DIV_W(DIV_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_load     (cmd_load),
        .load_val     (load_val),
        .cmd_run      (cmd_run),
        .cmd_single   (cmd_single),
        .cmd_stop     (cmd_stop),
        .period       (period),
        .max_gen      (max_gen),
        .alive_in     (alive_in),
        .val_out      (val_out),
        .write_enb_out(write_enb_out),
        .step_out     (step_out),
        .gen_count    (gen_count),
        .busy         (busy),
        .halt_reason  (halt_reason),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]       reason;
        logic [GEN_W-1:0] gens;
        int               steps;
        int               spacing;
    } exp_t;

    exp_t             exp_q[$];
    logic [CELLS-1:0] load_q[$];
    int               n_cmp = 0;
    int               n_fail = 0;
    logic [CELLS-1:0] m_grid;
    logic [GEN_W-1:0] m_gen;
    logic [CELLS-1:0] grid;

    function automatic logic [15:0] life_next(input logic [15:0] g);
        logic [15:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 &&
                            c + dc >= 0 && c + dc < 4 && g[(r + dr) * 4 + c + dc]) begin
                            cnt++;
                        end
                    end
                end
                n[r * 4 + c] = g[r * 4 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    // The tile array: loads on write_enb, advances one generation per step pulse.
    always @(posedge clk) begin
        if (reset) begin
            grid <= '0;
        end else if (write_enb_out) begin
            grid <= val_out;
        end else if (step_out) begin
            grid <= life_next(grid);
        end
    end
    assign alive_in = grid;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Generation-level model: how many generations the run completes, and why it stops.
    task automatic predict(input logic single, input int p, input int stop_at,
                           input logic [GEN_W-1:0] maxg, output exp_t e);
        int lim;
        int o;
        int k;
        logic [15:0] nxt;
        logic [1:0] why;
        logic [GEN_W-1:0] cnt;
        if (stop_at == 0) begin
            lim = 1000;
        end else begin
            // Each generation spans p WAIT cycles then STEP and CHECK.
            o   = stop_at - 1;
            lim = o / (p + 2) + (((o % (p + 2)) >= p) ? 1 : 0);
        end
        if (single && lim > 1) lim = 1;
        why = 2'b00;
        k   = 0;
        while (k < lim && why == 2'b00) begin
            nxt = life_next(m_grid);
            cnt = (m_gen == '1) ? m_gen : m_gen + 1'b1;
            if (nxt == 0) why = 2'b10;
            else if (nxt == m_grid) why = 2'b01;
            else if (maxg != 0 && cnt == maxg) why = 2'b11;
            m_grid = nxt;
            m_gen  = cnt;
            k++;
        end
        e.reason  = why;
        e.gens    = m_gen;
        e.steps   = k;
        e.spacing = p + 2;
    endtask

    // Monitor: pops expectations whenever the DUT presents a load, a step or done.
    initial begin
        int   cyc;
        int   last_step;
        int   steps_seen;
        logic step_prev;
        logic we_prev;
        exp_t e;
        cyc = 0;
        last_step = 0;
        steps_seen = 0;
        step_prev = 1'b0;
        we_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                steps_seen = 0;
                step_prev  = 1'b0;
                we_prev    = 1'b0;
            end else begin
                if (write_enb_out) begin
                    check("load pending at write_enb", load_q.size() > 0, 1);
                    check("write_enb single cycle", we_prev, 0);
                    if (load_q.size() > 0) check("val_out", val_out, load_q.pop_front());
                end
                if (step_out) begin
                    check("step low cycle between pulses", step_prev, 0);
                    if (steps_seen > 0 && exp_q.size() > 0)
                        check("step spacing", cyc - last_step, exp_q[0].spacing);
                    steps_seen++;
                    last_step = cyc;
                end
                if (done) begin
                    check("run pending at done", exp_q.size() > 0, 1);
                    check("busy low at done", busy, 0);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("gen_count", gen_count, e.gens);
                        check("halt_reason", halt_reason, e.reason);
                        check("step pulses", steps_seen, e.steps);
                    end
                    steps_seen = 0;
                end
                step_prev = step_out;
                we_prev   = write_enb_out;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            if (!busy) return;
            @(posedge clk);
            #1;
        end
        check("reached idle", busy, 0);
    endtask

    task automatic do_load(input logic [CELLS-1:0] v);
        wait_idle();
        load_q.push_back(v);
        load_val = v;
        cmd_load = 1'b1;
        @(posedge clk);
        #1;
        cmd_load = 1'b0;
        m_grid = v;
        m_gen  = '0;
    endtask

    task automatic do_run(input logic single, input int p, input logic [GEN_W-1:0] maxg,
                          input int stop_at, input int junk_at);
        exp_t e;
        wait_idle();
        period  = DIV_W'(p);
        max_gen = maxg;
        predict(single, p, stop_at, maxg, e);
        exp_q.push_back(e);
        if (single) cmd_single = 1'b1;
        else cmd_run = 1'b1;
        @(posedge clk);
        #1;
        cmd_single = 1'b0;
        cmd_run    = 1'b0;
        for (int i = 1; i < 5000; i++) begin
            if (i == stop_at) cmd_stop = 1'b1;
            // Commands while busy must be ignored entirely.
            if (i == junk_at && busy) begin
                cmd_load   = 1'b1;
                load_val   = CELLS'($urandom);
                cmd_run    = 1'b1;
                cmd_single = 1'b1;
            end
            @(posedge clk);
            #1;
            cmd_stop   = 1'b0;
            cmd_load   = 1'b0;
            cmd_run    = 1'b0;
            cmd_single = 1'b0;
            if (!busy) break;
        end
        check("run finished", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " write_enb_out"}, write_enb_out, 0);
        check({tag, " step_out"}, step_out, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " gen_count"}, gen_count, 0);
        check({tag, " halt_reason"}, halt_reason, 0);
        check({tag, " val_out"}, val_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int p;
        logic [GEN_W-1:0] mg;
        reset      = 1'b1;
        cmd_load   = 1'b0;
        load_val   = '0;
        cmd_run    = 1'b0;
        cmd_single = 1'b0;
        cmd_stop   = 1'b0;
        period     = '0;
        max_gen    = '0;
        m_grid     = '0;
        m_gen      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");

        // Blinker free run, period 3, stopped during the 6th CHECK.
        do_load(16'h0222);
        do_run(1'b0, 3, '0, 30, 0);
        // Block still life, single step.
        do_load(16'h0066);
        do_run(1'b1, 2, '0, 0, 0);
        // Lone cell dies after one generation.
        do_load(16'h0001);
        do_run(1'b0, 0, '0, 0, 0);
        // Generation limit on the blinker.
        do_load(16'h0222);
        do_run(1'b0, 0, 16'd4, 0, 0);
        // Stop in the first STEP cycle; a load while busy must not write.
        do_load(16'h0222);
        do_run(1'b0, 4, '0, 5, 3);

        // Reset during WAIT.
        wait_idle();
        period  = DIV_W'(50);
        max_gen = '0;
        cmd_run = 1'b1;
        @(posedge clk);
        #1;
        cmd_run = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("busy before mid-run reset", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("mid-run reset");
        m_grid = '0;
        m_gen  = '0;
        do_load(16'h0660);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                do_load(CELLS'($urandom));
            end else begin
                p  = int'($urandom_range(0, 6));
                mg = $urandom_range(0, 1) ? m_gen + GEN_W'($urandom_range(1, 10)) : '0;
                do_run(op == 1, p, mg, int'($urandom_range(1, 80)),
                       int'($urandom_range(1, 20)));
            end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("runs left unchecked", exp_q.size(), 0);
        check("loads left unchecked", load_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/life_ctrl.md
Name: life_ctrl

Overview:
- Sequencer for the life tile array (e.g. the 4x4 array).
- Loads an initial pattern, issues single-generation step pulses at a programmable rate, and counts generations.
- Detects halt conditions (grid empty, grid stable, generation limit) and reports status to the host or display logic.
- Sits between the host/button interface and the array's val/write_enb/step/alive ports.

Parameters:
- CELLS, 16, number of cells; width of pattern and alive buses.
- GEN_W, 16, width of generation counter and limit.
- DIV_W, 24, width of inter-step period counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_load  in  1  load load_val into the array (accepted in IDLE only).
- load_val  in  CELLS  pattern to load.
- cmd_run  in  1  start free-running generations (IDLE only).
- cmd_single  in  1  run exactly one generation (IDLE only).
- cmd_stop  in  1  stop free-running.
- period  in  DIV_W  idle cycles between generations; sampled at each WAIT entry.
- max_gen  in  GEN_W  generation limit; 0 = unlimited.
- alive_in  in  CELLS  array alive bus.
- val_out  out  CELLS  to array val.
- write_enb_out  out  1  to array write_enb.
- step_out  out  1  to array step.
- gen_count  out  GEN_W  generations since last load.
- busy  out  1  high when state != IDLE.
- halt_reason  out  2  00 none, 01 stable, 10 empty, 11 max_gen.
- done  out  1  one-cycle pulse on return to IDLE from any run.

Behaviour:
- Reset: state IDLE; all outputs 0; prev snapshot 0; stop latch 0.
- States: IDLE, LOAD, WAIT, STEP, CHECK.
- IDLE command priority: cmd_stop (no-op) > cmd_load > cmd_single > cmd_run; one command accepted per cycle.
- Accepting load, single or run clears halt_reason.
- IDLE -> LOAD:
  - LOAD lasts 1 cycle: write_enb_out=1, val_out=load_val (registered at accept).
  - Same cycle: prev <= load_val, gen_count <= 0.
  - LOAD -> IDLE; done is not pulsed.
- Run/single accept: mode latched (free or single), then -> WAIT.
- WAIT: down-counter loaded with period on entry; leaves when it reaches 0. period=0 skips WAIT with 0 cycles spent.
- STEP lasts 1 cycle: step_out=1. The array's internal edge detect yields exactly one generation. -> CHECK.
- CHECK lasts 1 cycle: step_out=0 (guarantees the low cycle between pulses).
  - alive_in now holds the new generation. gen_count increments, saturating at all-ones.
  - Halt evaluation, priority empty > stable > max_gen:
    - alive_in==0 -> 10.
    - alive_in==prev -> 01.
    - max_gen!=0 and incremented count==max_gen -> 11.
  - prev <= alive_in.
  - Exit: halt, single mode, or stop latch set -> IDLE with done=1 next cycle. Otherwise -> WAIT.
- Generation interval in free run: period+2 cycles.
- cmd_stop during WAIT -> IDLE next cycle with done=1; gen_count unchanged.
- cmd_stop during STEP/CHECK sets the stop latch. The generation completes, then IDLE with done. Latch clears on IDLE entry.
- cmd_load/run/single while busy: ignored, no side effects.
- A halt_reason of 00 with done means a user stop or a single step without a halt.
- reset mid-run: immediate IDLE; step_out and write_enb_out drop the same edge. The array is reset by the shared reset.
- Outputs are registered; no combinational path from cmd_* to array ports.

Decomposition:
- Package life_ctrl_pkg holds:
  - state encoding constants;
  - halt_reason codes (HALT_NONE, HALT_STABLE, HALT_EMPTY, HALT_MAXGEN);
  - default widths.
- Sub-module life_step_timer:
  - DIV_W down-counter with load/expire;
  - ports clk, reset, load, period, expired.

Test Plan:
- Blinker on 4x4: load 0x0222, run with period=3, max_gen=0. Required: alive toggles 0x0222/0x0070 every 5 cycles; no halt; stop then gives done with halt_reason 00.
- Block still life: load 0x0066, single. Required: after CHECK, halt_reason 01, gen_count 1, done high 1 cycle, busy low.
- Lone cell: load 0x0001, run period=0. Required: step_out pulses every 2 cycles; after gen 1 alive=0, halt_reason 10, gen_count 1.
- Generation limit: blinker, max_gen=4, period=0. Required: exactly 4 step_out pulses, halt_reason 11, gen_count 4.
- Stop timing: cmd_stop asserted in the STEP cycle. Required: one more CHECK, gen_count +1, then IDLE with done. cmd_load while busy has no write_enb_out.
- Reset mid-WAIT: all outputs 0 next cycle, state IDLE. A subsequent cmd_load gives write_enb_out for exactly 1 cycle.
